// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the asynchronous-serial transmitter.
//   - PARITY_* : encodings for the PARITY parameter of serial_tx
//   - tx_state_e : transmitter FSM states
//   - calc_parity : maps the XOR of the data bits to the transmitted parity bit
package serial_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // xor_all is the reduction XOR of the data bits. Odd parity makes the total
    // count of ones (data + parity) odd, so it transmits the inverse.
    function automatic logic calc_parity(input logic xor_all, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~xor_all : xor_all;
    endfunction

endpackage

// File: rtl/serial_fifo.sv
// serial_fifo: synchronous first-word-fall-through FIFO.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears pointers and occupancy
//   push  : write request; ignored while full (full is sampled before any pop)
//   pop   : read request; ignored while empty
//   wdata : data written on an accepted push
//   rdata : current head entry (valid while empty is low)
//   full  : registered, high when the FIFO holds DEPTH entries
//   empty : high when no entries are stored
//   level : registered occupancy, 0..DEPTH
module serial_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
    // that differ only in the wrap bit mean full.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] level_q;
    logic [AW:0] level_d;
    logic        full_q;
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    // A push into a full FIFO is rejected even when a pop happens in the
    // same cycle, keeping the overflow decision purely registered.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign level   = level_q;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LW'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + LW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + LW'(1);
            end
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parametrised asynchronous-serial transmitter with input FIFO.
// Frames are: start bit (0), DATA_BITS data bits LSB first, optional parity
// bit, STOP_BITS stop bits (1). Each bit lasts DIVISOR clocks.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset; aborts any frame, empties FIFO
//   char     : character to enqueue
//   send     : enqueue request, sampled every clock
//   full     : FIFO holds FIFO_DEPTH entries
//   overflow : one-cycle pulse the cycle after a send was rejected as full
//   level    : FIFO occupancy
//   out      : serial line, idle high, driven from a flop
//   busy     : a frame is being shifted or the FIFO is non-empty
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned DIVISOR    = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          char,
    input  logic                          send,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          out,
    output logic                          busy
);

    localparam int unsigned CntW = $clog2(DIVISOR);
    localparam int unsigned BitW = 3;

    tx_state_e             state_q;
    logic [CntW-1:0]       baud_cnt_q;
    logic [BitW-1:0]       bit_cnt_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  par_q;
    logic                  out_q;
    logic                  overflow_q;

    logic [DATA_BITS-1:0]  fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  bit_done;
    logic                  frame_done;

    serial_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (send),
        .pop   (fifo_pop),
        .wdata (char),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign bit_done   = (baud_cnt_q == CntW'(DIVISOR - 1));
    assign frame_done = (state_q == StStop) && bit_done &&
                        (bit_cnt_q == BitW'(STOP_BITS - 1));
    // Pop either from idle or on the last clock of the final stop bit, so a
    // queued character starts with no idle gap.
    assign fifo_pop   = !fifo_empty && ((state_q == StIdle) || frame_done);

    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign out      = out_q;
    assign busy     = (state_q != StIdle) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= send && fifo_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            out_q      <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    out_q      <= 1'b1;
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    if (fifo_pop) begin
                        shift_q <= fifo_rdata;
                        par_q   <= calc_parity(^fifo_rdata, PARITY);
                        out_q   <= 1'b0;
                        state_q <= StStart;
                    end
                end

                StStart: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        out_q      <= shift_q[0];
                        state_q    <= StData;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CntW'(1);
                    end
                end

                StData: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PARITY_NONE) begin
                                out_q   <= par_q;
                                state_q <= StParity;
                            end else begin
                                out_q   <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            // Shift right so the next bit is always at index 1.
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                            shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                            out_q     <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CntW'(1);
                    end
                end

                StParity: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        out_q      <= 1'b1;
                        state_q    <= StStop;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CntW'(1);
                    end
                end

                StStop: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        if (frame_done) begin
                            bit_cnt_q <= '0;
                            if (fifo_pop) begin
                                shift_q <= fifo_rdata;
                                par_q   <= calc_parity(^fifo_rdata, PARITY);
                                out_q   <= 1'b0;
                                state_q <= StStart;
                            end else begin
                                out_q   <= 1'b1;
                                state_q <= StIdle;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CntW'(1);
                    end
                end

                default: begin
                    out_q   <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: self-checking bench for serial_tx. Three instances cover
// different parameter sets; one is selected at a time through sel. Expected
// line/busy/level/full/overflow traces come from a cycle-level behavioural
// model built from frame timing rules; random traffic is also decoded by a
// mid-bit sampling UART receiver.
module tb_serial_tx;

    typedef bit bitq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tb_send = 1'b0;
    logic [7:0] tb_char = 8'h00;
    int         sel = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance A: 7 data bits, even parity, 1 stop, DIVISOR 4, depth 4
    logic       a_send, a_full, a_ovf, a_out, a_busy;
    logic [2:0] a_level;
    // Instance B: 8 data bits, no parity, 2 stops, DIVISOR 4, depth 4
    logic       b_send, b_full, b_ovf, b_out, b_busy;
    logic [2:0] b_level;
    // Instance C: 7 data bits, odd parity, 1 stop, DIVISOR 2, depth 8
    logic       c_send, c_full, c_ovf, c_out, c_busy;
    logic [3:0] c_level;

    assign a_send = tb_send && (sel == 0);
    assign b_send = tb_send && (sel == 1);
    assign c_send = tb_send && (sel == 2);

    serial_tx #(.DIVISOR(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .char(tb_char[6:0]), .send(a_send), .full(a_full),
        .overflow(a_ovf), .level(a_level), .out(a_out), .busy(a_busy));

    serial_tx #(.DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .char(tb_char), .send(b_send), .full(b_full),
        .overflow(b_ovf), .level(b_level), .out(b_out), .busy(b_busy));

    serial_tx #(.DIVISOR(2), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) u_c (
        .clk(clk), .rst(rst), .char(tb_char[6:0]), .send(c_send), .full(c_full),
        .overflow(c_ovf), .level(c_level), .out(c_out), .busy(c_busy));

    logic mon_out, mon_busy, mon_full, mon_ovf;
    int   mon_level;

    always_comb begin
        mon_out = a_out; mon_busy = a_busy; mon_full = a_full; mon_ovf = a_ovf;
        mon_level = int'(a_level);
        case (sel)
            1: begin
                mon_out = b_out; mon_busy = b_busy; mon_full = b_full; mon_ovf = b_ovf;
                mon_level = int'(b_level);
            end
            2: begin
                mon_out = c_out; mon_busy = c_busy; mon_full = c_full; mon_ovf = c_ovf;
                mon_level = int'(c_level);
            end
            default: ;
        endcase
    end

    // Stimulus (per cycle), observed and expected traces
    bit         stim_send[$];
    logic [7:0] stim_char[$];
    logic       obs_out[$], obs_busy[$], obs_full[$], obs_ovf[$];
    int         obs_level[$];
    logic       exp_out[$], exp_busy[$], exp_full[$], exp_ovf[$];
    int         exp_level[$];
    logic [7:0] acc_q[$];

    function automatic bitq_t make_frame(input logic [7:0] d, input int nbits, input int par,
                                         input int stops);
        bitq_t f;
        int    ones = 0;
        f.push_back(1'b0);
        for (int k = 0; k < nbits; k++) begin
            f.push_back(d[k]);
            ones += int'(d[k]);
        end
        if (par == 1) f.push_back((ones % 2) == 0);
        else if (par == 2) f.push_back((ones % 2) == 1);
        for (int k = 0; k < stops; k++) f.push_back(1'b1);
        return f;
    endfunction

    // Cycle-level reference: a frame runs for its bit count times div clocks; the
    // next character is taken when the line is idle or on the final frame clock.
    task automatic run_model(input int div, input int nbits, input int par, input int stops,
                             input int depth, input int ncyc);
        logic [7:0] q[$];
        bitq_t      bits;
        int         fstart = 0;
        int         fend = 0;
        bit         ovf_next = 0;
        bit         s, is_full, do_pop;
        exp_out.delete(); exp_busy.delete(); exp_full.delete(); exp_ovf.delete();
        exp_level.delete(); acc_q.delete();
        for (int t = 0; t < ncyc; t++) begin
            if (t >= fstart && t < fend) exp_out.push_back(bits[(t - fstart) / div]);
            else exp_out.push_back(1'b1);
            exp_busy.push_back((t < fend) || (q.size() > 0));
            exp_level.push_back(q.size());
            exp_full.push_back(q.size() == depth);
            exp_ovf.push_back(ovf_next);
            s        = (t < stim_send.size()) ? stim_send[t] : 1'b0;
            is_full  = (q.size() == depth);
            do_pop   = (t >= fend - 1) && (q.size() > 0);
            ovf_next = s && is_full;
            if (do_pop) begin
                bits   = make_frame(q.pop_front(), nbits, par, stops);
                fstart = t + 1;
                fend   = t + 1 + bits.size() * div;
            end
            if (s && !is_full) begin
                q.push_back(stim_char[t]);
                acc_q.push_back(stim_char[t]);
            end
        end
    endtask

    task automatic stim_at(input int idx, input logic [7:0] c);
        while (stim_send.size() <= idx) begin
            stim_send.push_back(1'b0);
            stim_char.push_back(8'h00);
        end
        stim_send[idx] = 1'b1;
        stim_char[idx] = c;
    endtask

    task automatic do_reset(input int s);
        sel = s;
        stim_send.delete();
        stim_char.delete();
        @(negedge clk);
        rst = 1'b1;
        tb_send = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Each iteration samples the cycle's outputs, then drives that cycle's inputs.
    task automatic record(input int ncyc);
        obs_out.delete(); obs_busy.delete(); obs_full.delete(); obs_ovf.delete();
        obs_level.delete();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            obs_out.push_back(mon_out);
            obs_busy.push_back(mon_busy);
            obs_full.push_back(mon_full);
            obs_ovf.push_back(mon_ovf);
            obs_level.push_back(mon_level);
            if (i < stim_send.size()) begin
                tb_send = stim_send[i];
                tb_char = stim_char[i];
            end else begin
                tb_send = 1'b0;
            end
        end
        tb_send = 1'b0;
    endtask

    // Number of cycles where any observed trace differs from the model.
    function automatic int stream_diffs(output int first);
        int n = 0;
        first = -1;
        if (obs_out.size() != exp_out.size()) return 1;
        for (int i = 0; i < obs_out.size(); i++) begin
            if (obs_out[i] !== exp_out[i] || obs_busy[i] !== exp_busy[i] ||
                obs_full[i] !== exp_full[i] || obs_ovf[i] !== exp_ovf[i] ||
                obs_level[i] != exp_level[i]) begin
                if (first < 0) first = i;
                n++;
            end
        end
        return n;
    endfunction

    task automatic test_reset();
        sel = 0;
        rst = 1'b1;
        tb_send = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({a_out, b_out, c_out} !== 3'b111) begin
            errors++; $display("FAIL reset_out: got %b want 111", {a_out, b_out, c_out});
        end
        checks++;
        if ({a_busy, b_busy, c_busy} !== 3'b000) begin
            errors++; $display("FAIL reset_busy: got %b want 000", {a_busy, b_busy, c_busy});
        end
        checks++;
        if ({a_full, b_full, c_full} !== 3'b000) begin
            errors++; $display("FAIL reset_full: got %b want 000", {a_full, b_full, c_full});
        end
        checks++;
        if ({a_ovf, b_ovf, c_ovf} !== 3'b000) begin
            errors++; $display("FAIL reset_overflow: got %b want 000", {a_ovf, b_ovf, c_ovf});
        end
        checks++;
        if (a_level !== 3'd0 || b_level !== 3'd0 || c_level !== 4'd0) begin
            errors++;
            $display("FAIL reset_level: got %0d/%0d/%0d want 0/0/0", a_level, b_level, c_level);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        do_reset(0);
        stim_at(0, 8'h00);
        stim_at(1, 8'h7F);
        stim_at(2, 8'h11);
        record(10);
        @(negedge clk);  // cycle 10: inside a data bit of 0x00
        checks++;
        if (a_out !== 1'b0) begin
            errors++; $display("FAIL midframe_pre_out: got %b want 0", a_out);
        end
        checks++;
        if (a_level !== 3'd2) begin
            errors++; $display("FAIL midframe_pre_level: got %0d want 2", a_level);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_out !== 1'b1) begin
            errors++; $display("FAIL midframe_reset_out: got %b want 1", a_out);
        end
        checks++;
        if (a_level !== 3'd0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset_state: got level %0d busy %b want 0 0", a_level, a_busy);
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (a_out !== 1'b1 || a_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL midframe_no_further_frame: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_single_even();
        int d, first;
        do_reset(0);
        stim_at(0, 8'h42);
        record(50);
        run_model(4, 7, 2, 1, 4, 50);
        d = stream_diffs(first);
        checks++;
        if (d !== 0) begin
            errors++; $display("FAIL single_even_stream: got %0d bad cycles (first %0d) want 0", d, first);
        end
        checks++;
        if (obs_out[1] !== 1'b1 || obs_out[2] !== 1'b0) begin
            errors++;
            $display("FAIL single_start_latency: got %b%b want 10", obs_out[1], obs_out[2]);
        end
        checks++;
        if (obs_out[34] !== 1'b0) begin
            errors++; $display("FAIL single_even_parity: got %b want 0", obs_out[34]);
        end
        checks++;
        if (obs_busy[41] !== 1'b1 || obs_busy[42] !== 1'b0) begin
            errors++;
            $display("FAIL single_frame_len: got busy %b%b want 10", obs_busy[41], obs_busy[42]);
        end
    endtask

    task automatic test_single_odd();
        int d, first;
        do_reset(2);
        stim_at(0, 8'h42);
        record(30);
        run_model(2, 7, 1, 1, 8, 30);
        d = stream_diffs(first);
        checks++;
        if (d !== 0) begin
            errors++; $display("FAIL single_odd_stream: got %0d bad cycles (first %0d) want 0", d, first);
        end
        checks++;
        if (obs_out[18] !== 1'b1) begin
            errors++; $display("FAIL single_odd_parity: got %b want 1", obs_out[18]);
        end
        checks++;
        if (obs_busy[21] !== 1'b1 || obs_busy[22] !== 1'b0) begin
            errors++;
            $display("FAIL single_odd_frame_len: got busy %b%b want 10", obs_busy[21], obs_busy[22]);
        end
    endtask

    task automatic test_back_to_back();
        int d, first, hi = 0;
        do_reset(1);
        stim_at(0, 8'h41);
        stim_at(1, 8'h42);
        stim_at(2, 8'h43);
        record(150);
        run_model(4, 8, 0, 2, 4, 150);
        d = stream_diffs(first);
        checks++;
        if (d !== 0) begin
            errors++; $display("FAIL b2b_stream: got %0d bad cycles (first %0d) want 0", d, first);
        end
        for (int i = 1; i <= 133; i++) hi += int'(obs_busy[i]);
        checks++;
        if (hi !== 133 || obs_busy[134] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: got %0d high then %b want 133 high then 0", hi, obs_busy[134]);
        end
        checks++;
        if (obs_out[45] !== 1'b1 || obs_out[46] !== 1'b0 || obs_out[90] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_gap: got %b%b%b want 100", obs_out[45], obs_out[46], obs_out[90]);
        end
    endtask

    task automatic test_fill();
        int d, first, pulses = 0;
        do_reset(1);
        stim_at(0, 8'h30);
        for (int k = 0; k < 6; k++) stim_at(5 + k, 8'h61 + 8'(k));
        record(260);
        run_model(4, 8, 0, 2, 4, 260);
        d = stream_diffs(first);
        checks++;
        if (d !== 0) begin
            errors++; $display("FAIL fill_stream: got %0d bad cycles (first %0d) want 0", d, first);
        end
        checks++;
        if (obs_full[8] !== 1'b0 || obs_full[9] !== 1'b1) begin
            errors++;
            $display("FAIL fill_full_timing: got %b%b want 01", obs_full[8], obs_full[9]);
        end
        foreach (obs_ovf[i]) pulses += int'(obs_ovf[i]);
        checks++;
        if (pulses !== 2 || obs_ovf[10] !== 1'b1 || obs_ovf[11] !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow: got %0d pulses want 2 at cycles 10,11", pulses);
        end
    endtask

    task automatic test_push_full_pop();
        int d, first;
        do_reset(1);
        for (int k = 0; k < 5; k++) stim_at(k, 8'hA0 + 8'(k));
        stim_at(45, 8'hEE);  // same cycle as the pop at the end of frame one
        record(240);
        run_model(4, 8, 0, 2, 4, 240);
        d = stream_diffs(first);
        checks++;
        if (d !== 0) begin
            errors++; $display("FAIL pushfull_stream: got %0d bad cycles (first %0d) want 0", d, first);
        end
        checks++;
        if (obs_full[45] !== 1'b1 || obs_ovf[46] !== 1'b1) begin
            errors++;
            $display("FAIL pushfull_overflow: got full %b ovf %b want 1 1", obs_full[45], obs_ovf[46]);
        end
        checks++;
        if (obs_level[45] != 4 || obs_level[46] != 3) begin
            errors++;
            $display("FAIL pushfull_level: got %0d->%0d want 4->3", obs_level[45], obs_level[46]);
        end
    endtask

    task automatic test_random();
        int         d, first, idx = 1, ncyc, i, start, ones, frame_err = 0, order_err = 0;
        logic [7:0] rx_q[$];
        logic [7:0] v;
        do_reset(2);
        for (int n = 0; n < 1000; n++) begin
            idx += int'($urandom_range(1, 44));
            stim_at(idx, 8'($urandom_range(0, 127)));
        end
        ncyc = idx + 8 * 20 + 40;
        record(ncyc);
        run_model(2, 7, 1, 1, 8, ncyc);
        d = stream_diffs(first);
        checks++;
        if (d !== 0) begin
            errors++; $display("FAIL random_stream: got %0d bad cycles (first %0d) want 0", d, first);
        end
        // Reference receiver: find a falling edge, sample each bit mid-period.
        i = 1;
        while (i < obs_out.size()) begin
            if (obs_out[i] === 1'b0 && obs_out[i-1] === 1'b1) begin
                start = i;
                if (start + 20 > obs_out.size()) begin
                    frame_err++;
                    break;
                end
                v = 8'h00;
                ones = 0;
                for (int k = 0; k < 7; k++) begin
                    v[k] = obs_out[start + (k + 1) * 2 + 1];
                    ones += int'(v[k]);
                end
                ones += int'(obs_out[start + 8 * 2 + 1]);
                if (obs_out[start + 1] !== 1'b0 || obs_out[start + 9 * 2 + 1] !== 1'b1 ||
                    (ones % 2) != 1) frame_err++;
                rx_q.push_back(v);
                i = start + 20;
            end else begin
                i++;
            end
        end
        checks++;
        if (frame_err !== 0) begin
            errors++; $display("FAIL random_framing: got %0d framing/parity errors want 0", frame_err);
        end
        checks++;
        if (rx_q.size() !== acc_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d received want %0d", rx_q.size(), acc_q.size());
        end
        for (int k = 0; k < rx_q.size() && k < acc_q.size(); k++) begin
            if (rx_q[k] !== acc_q[k]) order_err++;
        end
        checks++;
        if (order_err !== 0) begin
            errors++; $display("FAIL random_order: got %0d wrong characters want 0", order_err);
        end
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_single_even();
        test_single_odd();
        test_back_to_back();
        test_fill();
        test_push_full_pop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
